// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI request arbiter: FSM encoding and field widths.
package qspi_pkg;

  localparam int INST_W     = 8;
  localparam int SIZE_W     = 8;
  localparam int DEF_ADDR_W = 24;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/qspi_rr_pick.sv
// Rotating-priority picker: returns the first set bit of valid_i at or after
// ptr_i, wrapping modulo NUM_CH (NUM_CH need not be a power of two).
module qspi_rr_pick #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [PTR_W-1:0]  winner_o,
  output logic              any_o
);

  logic [NUM_CH-1:0] rot;
  logic [PTR_W-1:0]  off;
  logic [PTR_W:0]    sum;

  // rot[i] is the channel i positions past the pointer
  always_comb begin
    rot = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (ptr_i == PTR_W'(j)) begin
        for (int i = 0; i < NUM_CH; i++) begin
          rot[i] = valid_i[(i + j) % NUM_CH];
        end
      end
    end
  end

  always_comb begin
    off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = PTR_W'(i);
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (PTR_W + 1)'(NUM_CH)) begin
      sum = sum - (PTR_W + 1)'(NUM_CH);
    end
  end

  assign winner_o = sum[PTR_W-1:0];
  assign any_o    = |valid_i;

endmodule

// File: rtl/qspi_req_arbiter.sv
// Round-robin arbiter granting one of NUM_CH request channels to the QSPI control level.
// Optional watchdog abort enabled with `define QSPI_ARB_TIMEOUT_EN.
module qspi_req_arbiter
  import qspi_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          io_req_valid,
  output logic [NUM_CH-1:0]          io_req_ready,
  input  logic [NUM_CH*INST_W-1:0]   io_req_inst,
  input  logic [NUM_CH*ADDR_W-1:0]   io_req_addr,
  input  logic [NUM_CH*SIZE_W-1:0]   io_req_data_size,
  input  logic [NUM_CH*SIZE_W-1:0]   io_req_data_burstlen,
  output logic                       io_ctrl_req_valid,
  input  logic                       io_ctrl_req_ready,
  output logic [INST_W-1:0]          io_ctrl_req_inst,
  output logic [ADDR_W-1:0]          io_ctrl_req_addr,
  output logic [SIZE_W-1:0]          io_ctrl_req_data_size,
  output logic [SIZE_W-1:0]          io_ctrl_req_data_burstlen,
  input  logic                       io_ctrl_done,
  output logic [$clog2(NUM_CH)-1:0]  io_grant_id,
  output logic                       io_busy,
  output logic                       io_timeout
);

  localparam int PTR_W = $clog2(NUM_CH);

  arb_state_e        state_q;
  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic [PTR_W-1:0]  grant_q;
  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SIZE_W-1:0] size_q;
  logic [SIZE_W-1:0] burst_q;
  logic              valid_q;
  logic              busy_q;
  logic              timeout_q;

  logic [PTR_W-1:0]  win;
  logic              any;
  logic              expire;

  qspi_rr_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_pick (
    .valid_i  (io_req_valid),
    .ptr_i    (rr_ptr_q),
    .winner_o (win),
    .any_o    (any)
  );

  assign rr_ptr_d = (win == PTR_W'(NUM_CH - 1)) ? '0 : win + 1'b1;

  // Accept is combinational so the winning channel sees ready in its request cycle
  always_comb begin
    io_req_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      io_req_ready[i] = !reset && (state_q == IDLE) && any && (win == PTR_W'(i));
    end
  end

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q;

  // Held at zero while idle, so it starts from zero on entry to REQ
  always_ff @(posedge clock) begin
    if (reset || state_q == IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  localparam int timeout_unused = TIMEOUT_CYC;
  assign expire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      inst_q    <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any) begin
            inst_q   <= io_req_inst[win*INST_W +: INST_W];
            addr_q   <= io_req_addr[win*ADDR_W +: ADDR_W];
            size_q   <= io_req_data_size[win*SIZE_W +: SIZE_W];
            burst_q  <= io_req_data_burstlen[win*SIZE_W +: SIZE_W];
            grant_q  <= win;
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (expire) begin
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else if (io_ctrl_req_ready) begin
            valid_q <= 1'b0;
            state_q <= WAIT_DONE;
          end
        end
        // A done pulse on the expiry cycle completes normally
        WAIT_DONE: begin
          if (io_ctrl_done) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (expire) begin
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign io_ctrl_req_valid         = valid_q;
  assign io_ctrl_req_inst          = inst_q;
  assign io_ctrl_req_addr          = addr_q;
  assign io_ctrl_req_data_size     = size_q;
  assign io_ctrl_req_data_burstlen = burst_q;
  assign io_grant_id               = grant_q;
  assign io_busy                   = busy_q;
  assign io_timeout                = timeout_q;

endmodule
